// File: rtl/hwpe_stream_deserialize.sv
// Deals a single HWPE-Stream round-robin over NB_OUT_STREAMS outputs, nb_contig_m1+1 beats per lane.
// SYNC_VALID=1 instead gathers one beat per lane and releases them all together.
module hwpe_stream_deserialize #(
    parameter int unsigned NB_OUT_STREAMS = 2,
    parameter int unsigned CONTIG_LIMIT   = 1024,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter bit          SYNC_VALID     = 1'b0,
    parameter int unsigned FIRST_STREAM_W = 8,
    parameter int unsigned NB_CONTIG_W    = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         clear_i,
    input  logic                                         ctrl_clear_serdes_state_i,
    input  logic [FIRST_STREAM_W-1:0]                    ctrl_first_stream_i,
    input  logic [NB_CONTIG_W-1:0]                       ctrl_nb_contig_m1_i,
    input  logic                                         push_valid_i,
    output logic                                         push_ready_o,
    input  logic [DATA_WIDTH-1:0]                        push_data_i,
    input  logic [STRB_WIDTH-1:0]                        push_strb_i,
    output logic [NB_OUT_STREAMS-1:0]                    pop_valid_o,
    input  logic [NB_OUT_STREAMS-1:0]                    pop_ready_i,
    output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH-1:0]    pop_data_o,
    output logic [NB_OUT_STREAMS-1:0][STRB_WIDTH-1:0]    pop_strb_o
);

    localparam int unsigned STREAM_W = (NB_OUT_STREAMS > 1) ? $clog2(NB_OUT_STREAMS) : 1;
    localparam int unsigned CONTIG_W = (CONTIG_LIMIT > 1) ? $clog2(CONTIG_LIMIT) : 1;

    logic [STREAM_W-1:0] r_stream_cnt;
    logic [STREAM_W-1:0] w_first_stream;

    // Out-of-range first_stream requests fall back to lane 0
    assign w_first_stream = (32'(ctrl_first_stream_i) >= NB_OUT_STREAMS) ?
                            '0 : STREAM_W'(ctrl_first_stream_i);

    if (SYNC_VALID == 1'b0) begin : g_pass
        logic [CONTIG_W-1:0] r_contig_cnt;
        logic [CONTIG_W-1:0] w_limit;
        logic                w_push_hs;

        assign w_limit = (32'(ctrl_nb_contig_m1_i) > CONTIG_LIMIT - 1) ?
                         CONTIG_W'(CONTIG_LIMIT - 1) : CONTIG_W'(ctrl_nb_contig_m1_i);
        assign w_push_hs = push_valid_i & push_ready_o;

        // Only the selected lane sees valid and drives ready back; payload is broadcast
        always_comb begin
            push_ready_o = 1'b0;
            pop_valid_o  = '0;
            pop_data_o   = '0;
            pop_strb_o   = '0;
            for (int unsigned k = 0; k < NB_OUT_STREAMS; k++) begin
                pop_data_o[k] = push_data_i;
                pop_strb_o[k] = push_strb_i;
                if (32'(r_stream_cnt) == k) begin
                    pop_valid_o[k] = push_valid_i;
                    push_ready_o   = pop_ready_i[k];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_stream_cnt <= '0;
                r_contig_cnt <= '0;
            end else if (clear_i) begin
                r_stream_cnt <= '0;
                r_contig_cnt <= '0;
            end else if (ctrl_clear_serdes_state_i) begin
                r_stream_cnt <= w_first_stream;
                r_contig_cnt <= '0;
            end else if (w_push_hs) begin
                if (r_contig_cnt < w_limit) begin
                    r_contig_cnt <= CONTIG_W'(r_contig_cnt + 1'b1);
                end else begin
                    r_contig_cnt <= '0;
                    r_stream_cnt <= (32'(r_stream_cnt) == NB_OUT_STREAMS - 1) ?
                                    '0 : STREAM_W'(r_stream_cnt + 1'b1);
                end
            end
        end
    end else begin : g_sync
        typedef enum logic {FILL, DRAIN} state_e;

        state_e                                   r_state, w_state_d;
        logic [NB_OUT_STREAMS-1:0]                r_pend, w_pend_d, w_buf_we;
        logic [STREAM_W-1:0]                      w_stream_d;
        logic [NB_OUT_STREAMS-1:0][DATA_WIDTH-1:0] r_buf_data;
        logic [NB_OUT_STREAMS-1:0][STRB_WIDTH-1:0] r_buf_strb;
        logic                                     w_unused_nb;

        // Contiguity is fixed at one beat per lane in this mode
        assign w_unused_nb = ^ctrl_nb_contig_m1_i;
        assign pop_data_o  = r_buf_data;
        assign pop_strb_o  = r_buf_strb;

        always_comb begin
            w_state_d    = r_state;
            w_stream_d   = r_stream_cnt;
            w_pend_d     = r_pend;
            w_buf_we     = '0;
            push_ready_o = 1'b0;
            pop_valid_o  = '0;
            case (r_state)
                FILL: begin
                    push_ready_o = 1'b1;
                    if (push_valid_i) begin
                        for (int unsigned k = 0; k < NB_OUT_STREAMS; k++) begin
                            if (32'(r_stream_cnt) == k) w_buf_we[k] = 1'b1;
                        end
                        if (32'(r_stream_cnt) == NB_OUT_STREAMS - 1) begin
                            w_pend_d   = '1;
                            w_state_d  = DRAIN;
                            w_stream_d = '0;
                        end else begin
                            w_stream_d = STREAM_W'(r_stream_cnt + 1'b1);
                        end
                    end
                end
                DRAIN: begin
                    pop_valid_o = r_pend;
                    w_pend_d    = r_pend & ~pop_ready_i;
                    if (w_pend_d == '0) w_state_d = FILL;
                end
                default: w_state_d = FILL;
            endcase
            // A same-cycle write still lands in the old lane's buffer
            if (ctrl_clear_serdes_state_i) begin
                w_stream_d = w_first_stream;
                w_pend_d   = '0;
                w_state_d  = FILL;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state      <= FILL;
                r_stream_cnt <= '0;
                r_pend       <= '0;
            end else if (clear_i) begin
                r_state      <= FILL;
                r_stream_cnt <= '0;
                r_pend       <= '0;
            end else begin
                r_state      <= w_state_d;
                r_stream_cnt <= w_stream_d;
                r_pend       <= w_pend_d;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_buf_data <= '0;
                r_buf_strb <= '0;
            end else begin
                for (int unsigned k = 0; k < NB_OUT_STREAMS; k++) begin
                    if (w_buf_we[k]) begin
                        r_buf_data[k] <= push_data_i;
                        r_buf_strb[k] <= push_strb_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_deserialize.sv
// Bench for hwpe_stream_deserialize: pass-through with N=2 and N=3 (clamped contig), gather mode with N=4.
module tb_hwpe_stream_deserialize;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    always #5 clk = ~clk;

    logic a_valid, a_ready, a_clr;
    logic [DW-1:0] a_data;
    logic [SW-1:0] a_strb;
    logic [7:0] a_first;
    logic [15:0] a_nb;
    logic [1:0] a_pv, a_pr;
    logic [1:0][DW-1:0] a_pd;
    logic [1:0][SW-1:0] a_ps;

    logic b_valid, b_ready, b_clr;
    logic [DW-1:0] b_data;
    logic [SW-1:0] b_strb;
    logic [7:0] b_first;
    logic [15:0] b_nb;
    logic [2:0] b_pv, b_pr;
    logic [2:0][DW-1:0] b_pd;
    logic [2:0][SW-1:0] b_ps;

    logic c_valid, c_ready, c_clr;
    logic [DW-1:0] c_data;
    logic [SW-1:0] c_strb;
    logic [7:0] c_first;
    logic [15:0] c_nb;
    logic [3:0] c_pv, c_pr;
    logic [3:0][DW-1:0] c_pd;
    logic [3:0][SW-1:0] c_ps;

    hwpe_stream_deserialize #(.NB_OUT_STREAMS(2), .CONTIG_LIMIT(1024), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .SYNC_VALID(1'b0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .ctrl_clear_serdes_state_i(a_clr), .ctrl_first_stream_i(a_first), .ctrl_nb_contig_m1_i(a_nb),
        .push_valid_i(a_valid), .push_ready_o(a_ready), .push_data_i(a_data), .push_strb_i(a_strb),
        .pop_valid_o(a_pv), .pop_ready_i(a_pr), .pop_data_o(a_pd), .pop_strb_o(a_ps));

    hwpe_stream_deserialize #(.NB_OUT_STREAMS(3), .CONTIG_LIMIT(4), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .SYNC_VALID(1'b0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .ctrl_clear_serdes_state_i(b_clr), .ctrl_first_stream_i(b_first), .ctrl_nb_contig_m1_i(b_nb),
        .push_valid_i(b_valid), .push_ready_o(b_ready), .push_data_i(b_data), .push_strb_i(b_strb),
        .pop_valid_o(b_pv), .pop_ready_i(b_pr), .pop_data_o(b_pd), .pop_strb_o(b_ps));

    hwpe_stream_deserialize #(.NB_OUT_STREAMS(4), .CONTIG_LIMIT(1024), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .SYNC_VALID(1'b1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .ctrl_clear_serdes_state_i(c_clr), .ctrl_first_stream_i(c_first), .ctrl_nb_contig_m1_i(c_nb),
        .push_valid_i(c_valid), .push_ready_o(c_ready), .push_data_i(c_data), .push_strb_i(c_strb),
        .pop_valid_o(c_pv), .pop_ready_i(c_pr), .pop_data_o(c_pd), .pop_strb_o(c_ps));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [1:0]  rdy;
        logic        epr;
        logic [1:0]  epv;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        a_valid = 1'b0; a_clr = 1'b0;
        b_valid = 1'b0; b_clr = 1'b0;
        c_valid = 1'b0; c_clr = 1'b0; c_pr = '0;
    endtask

    task automatic a_cyc(input logic v, input logic [31:0] d, input logic [1:0] rdy, input logic clr,
                         input logic [7:0] first, input logic epr, input logic [1:0] epv, input string nm);
        @(negedge clk);
        idle_all();
        a_valid = v; a_data = d; a_strb = d[3:0]; a_pr = rdy; a_clr = clr; a_first = first;
        #1;
        chk({nm, " push_ready"}, 64'(a_ready), 64'(epr));
        chk({nm, " pop_valid"}, 64'(a_pv), 64'(epv));
        if (v) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("%s data%0d", nm, k), 64'(a_pd[k]), 64'(d));
                chk($sformatf("%s strb%0d", nm, k), 64'(a_ps[k]), 64'(d[3:0]));
            end
        end
    endtask

    task automatic b_cyc(input logic v, input logic [31:0] d, input logic [2:0] rdy, input logic clr,
                         input logic [7:0] first, input logic [15:0] nb, input logic epr,
                         input logic [2:0] epv, input string nm);
        @(negedge clk);
        idle_all();
        b_valid = v; b_data = d; b_strb = d[3:0]; b_pr = rdy; b_clr = clr; b_first = first; b_nb = nb;
        #1;
        chk({nm, " push_ready"}, 64'(b_ready), 64'(epr));
        chk({nm, " pop_valid"}, 64'(b_pv), 64'(epv));
        if (v) begin
            for (int k = 0; k < 3; k++) chk($sformatf("%s data%0d", nm, k), 64'(b_pd[k]), 64'(d));
        end
    endtask

    task automatic c_cyc(input logic v, input logic [31:0] d, input logic [3:0] rdy, input logic clr,
                         input logic [7:0] first, input logic epr, input logic [3:0] epv,
                         input logic [3:0][31:0] ed, input string nm);
        @(negedge clk);
        idle_all();
        c_valid = v; c_data = d; c_strb = d[3:0]; c_pr = rdy; c_clr = clr; c_first = first;
        #1;
        chk({nm, " push_ready"}, 64'(c_ready), 64'(epr));
        chk({nm, " pop_valid"}, 64'(c_pv), 64'(epv));
        for (int k = 0; k < 4; k++) begin
            if (epv[k]) begin
                chk($sformatf("%s data%0d", nm, k), 64'(c_pd[k]), 64'(ed[k]));
                chk($sformatf("%s strb%0d", nm, k), 64'(c_ps[k]), 64'(ed[k][3:0]));
            end
        end
    endtask

    // Reference for pass-through: lane of the j-th beat since the last state clear
    function automatic int lane_of(input int first, input int j, input int lim, input int n);
        return (first + j / (lim + 1)) % n;
    endfunction

    initial begin
        logic [3:0][31:0] ed;
        logic [3:0] pend;
        logic [3:0] rdy4;
        logic [2:0] rdy3;
        logic       v;
        logic [31:0] d;
        int mf, mj, ml, nb, fs, sel;

        rst_n = 1'b0; clear = 1'b0;
        a_valid = 0; a_data = 0; a_strb = 0; a_pr = 0; a_clr = 0; a_first = 0; a_nb = 16'd0;
        b_valid = 0; b_data = 0; b_strb = 0; b_pr = 0; b_clr = 0; b_first = 0; b_nb = 16'd2;
        c_valid = 0; c_data = 0; c_strb = 0; c_pr = 0; c_clr = 0; c_first = 0; c_nb = 16'd7;
        ed = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        a_cyc(0, 0, 2'b10, 0, 0, 0, 2'b00, "a_reset");
        b_cyc(0, 0, 3'b110, 0, 0, 2, 0, 3'b000, "b_reset");
        c_cyc(0, 0, 4'hF, 0, 0, 1, 4'h0, ed, "c_reset");

        // N=2, one beat per lane: alternation, stalls on the selected lane's ready
        vt[0]  = '{1'b1, 32'hA, 2'b11, 1'b1, 2'b01};
        vt[1]  = '{1'b1, 32'hB, 2'b11, 1'b1, 2'b10};
        vt[2]  = '{1'b1, 32'hC, 2'b11, 1'b1, 2'b01};
        vt[3]  = '{1'b1, 32'hD, 2'b11, 1'b1, 2'b10};
        vt[4]  = '{1'b0, 32'h0, 2'b11, 1'b1, 2'b00};
        vt[5]  = '{1'b1, 32'hE, 2'b11, 1'b1, 2'b01};
        vt[6]  = '{1'b1, 32'hF, 2'b01, 1'b0, 2'b10};
        vt[7]  = '{1'b1, 32'hF, 2'b01, 1'b0, 2'b10};
        vt[8]  = '{1'b1, 32'hF, 2'b11, 1'b1, 2'b10};
        vt[9]  = '{1'b1, 32'h17, 2'b10, 1'b0, 2'b01};
        vt[10] = '{1'b1, 32'h17, 2'b01, 1'b1, 2'b01};
        vt[11] = '{1'b0, 32'h0, 2'b10, 1'b1, 2'b00};
        for (int i = 0; i < 12; i++)
            a_cyc(vt[i].v, vt[i].d, vt[i].rdy, 0, 0, vt[i].epr, vt[i].epv, $sformatf("a_vec%0d", i));

        // clear_serdes_state: same-cycle beat goes to the old lane; out-of-range first_stream -> lane 0
        a_cyc(1, 32'h21, 2'b11, 0, 0, 1, 2'b10, "a_h");
        a_cyc(1, 32'h22, 2'b11, 1, 1, 1, 2'b01, "a_clr_hs");
        a_cyc(1, 32'h23, 2'b11, 0, 0, 1, 2'b10, "a_after_clr");
        a_cyc(1, 32'h24, 2'b11, 0, 0, 1, 2'b01, "a_k");
        a_cyc(0, 32'h0, 2'b11, 1, 5, 1, 2'b00, "a_clr_first5");
        a_cyc(1, 32'h25, 2'b11, 0, 0, 1, 2'b01, "a_after_first5");

        // N=3, three beats per lane, then a clamped limit of 4 beats
        for (int j = 0; j < 10; j++)
            b_cyc(1, 32'(j), 3'b111, 0, 0, 2, 1, 3'(1 << lane_of(0, j, 2, 3)), $sformatf("b_contig%0d", j));
        b_cyc(0, 0, 3'b111, 1, 2, 9, 1, 3'b000, "b_clr_clamp");
        for (int j = 0; j < 8; j++)
            b_cyc(1, 32'(100 + j), 3'b111, 0, 0, 9, 1, 3'(1 << lane_of(2, j, 3, 3)), $sformatf("b_clamp%0d", j));

        // Randomized segments against the arithmetic lane model
        for (int s = 0; s < 6; s++) begin
            nb = $urandom_range(0, 6);
            fs = $urandom_range(0, 4);
            mf = (fs >= 3) ? 0 : fs;
            ml = (nb > 3) ? 3 : nb;
            mj = 0;
            b_cyc(0, 0, 3'b111, 1, 8'(fs), 16'(nb), 1, 3'b000, "b_rnd_clr");
            for (int c = 0; c < 50; c++) begin
                v    = 1'($urandom);
                d    = $urandom;
                rdy3 = 3'($urandom);
                sel  = lane_of(mf, mj, ml, 3);
                b_cyc(v, d, rdy3, 0, 0, 16'(nb), rdy3[sel], v ? 3'(1 << sel) : 3'b000, $sformatf("b_rnd%0d_%0d", s, c));
                if (v && rdy3[sel]) mj++;
            end
        end

        // Gather mode: fill 10..13, staggered drain, push ignored while draining
        for (int k = 0; k < 4; k++) begin
            ed[k] = 32'(10 + k);
            c_cyc(1, ed[k], 4'h0, 0, 0, 1, 4'h0, ed, $sformatf("c_fill%0d", k));
        end
        c_cyc(0, 0, 4'b0001, 0, 0, 0, 4'hF, ed, "c_drain0");
        c_cyc(0, 0, 4'b0100, 0, 0, 0, 4'hE, ed, "c_drain1");
        c_cyc(1, 32'h99, 4'b1010, 0, 0, 0, 4'hA, ed, "c_drain2");
        c_cyc(0, 0, 4'h0, 0, 0, 1, 4'h0, ed, "c_bubble");
        for (int k = 0; k < 4; k++) begin
            ed[k] = 32'(70 + k);
            c_cyc(1, ed[k], 4'h0, 0, 0, 1, 4'h0, ed, $sformatf("c_fill7%0d", k));
        end
        c_cyc(0, 0, 4'hF, 0, 0, 0, 4'hF, ed, "c_drain_all");
        c_cyc(0, 0, 4'h0, 0, 0, 1, 4'h0, ed, "c_bubble2");

        // Randomized fills with gaps and random drain readies
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) c_cyc(0, $urandom, 4'($urandom), 0, 0, 1, 4'h0, ed, "c_rnd_idle");
                ed[k] = $urandom;
                c_cyc(1, ed[k], 4'($urandom), 0, 0, 1, 4'h0, ed, "c_rnd_fill");
            end
            pend = 4'hF;
            for (int i = 0; i < 20; i++) begin
                rdy4 = (i >= 15) ? 4'hF : 4'($urandom);
                c_cyc(1'($urandom), $urandom, rdy4, 0, 0, 0, pend, ed, $sformatf("c_rnd_drain%0d_%0d", r, i));
                pend = pend & ~rdy4;
                if (pend == 4'h0) break;
            end
            c_cyc(0, 0, 4'h0, 0, 0, 1, 4'h0, ed, "c_rnd_bubble");
        end

        // Asynchronous reset mid-burst
        for (int k = 0; k < 4; k++) c_cyc(1, 32'(80 + k), 4'h0, 0, 0, 1, 4'h0, ed, "c_pre_rst_fill");
        b_cyc(0, 0, 3'b111, 1, 1, 2, 1, 3'b000, "b_pre_rst_clr");
        b_cyc(1, 32'h5, 3'b111, 0, 0, 2, 1, 3'b010, "b_pre_rst");
        @(negedge clk);
        idle_all();
        rst_n = 1'b0;
        #1;
        chk("c_rst_pop_valid", 64'(c_pv), 64'(0));
        chk("a_rst_pop_valid", 64'(a_pv), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        a_cyc(1, 32'hA0, 2'b11, 0, 0, 1, 2'b01, "a_post_rst");
        for (int j = 0; j < 4; j++)
            b_cyc(1, 32'(j), 3'b111, 0, 0, 2, 1, 3'(1 << lane_of(0, j, 2, 3)), $sformatf("b_post_rst%0d", j));
        c_cyc(0, 0, 4'hF, 0, 0, 1, 4'h0, ed, "c_post_rst");

        // Synchronous clear mid-drain and mid-burst
        for (int k = 0; k < 4; k++) begin
            ed[k] = 32'(90 + k);
            c_cyc(1, ed[k], 4'h0, 0, 0, 1, 4'h0, ed, "c_pre_clr_fill");
        end
        c_cyc(0, 0, 4'h0, 0, 0, 0, 4'hF, ed, "c_pre_clear");
        b_cyc(1, 32'h6, 3'b111, 0, 0, 2, 1, 3'b010, "b_pre_clear");
        @(negedge clk);
        idle_all();
        clear = 1'b1;
        #1;
        chk("c_clear_cycle_pop_valid", 64'(c_pv), 64'hF);
        @(negedge clk);
        clear = 1'b0;
        c_cyc(0, 0, 4'hF, 0, 0, 1, 4'h0, ed, "c_post_clear");
        for (int j = 0; j < 4; j++)
            b_cyc(1, 32'(j), 3'b111, 0, 0, 2, 1, 3'(1 << lane_of(0, j, 2, 3)), $sformatf("b_post_clear%0d", j));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
